// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: three-stage Karatsuba multiplier with valid/ready flow control and tag passthrough.
// Define KMUL_SIGNED_EN to honour in_signed (two's-complement operands); default build is unsigned only.
module karatsuba_mult_pipe #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int HALF = WIDTH / 2;
   localparam int SW = HALF + 1;
   localparam int Z1W = WIDTH + 2;
   localparam int PW = 2 * WIDTH + 2;

   logic v1, v2, v3, adv2, adv3, take;
   logic [HALF-1:0] lx, hx, ly, hy;
   logic [SW-1:0] sx, sy;
   logic [WIDTH-1:0] z0, z2, mx, my;
   logic [Z1W-1:0] z1;
   logic [TAG_W-1:0] t1, t2;
   logic [PW-1:0] mid;
   logic [2*WIDTH-1:0] prod, res;

   assign adv3 = out_ready || !v3;
   assign adv2 = !v2 || adv3;
   assign in_ready = !v1 || adv2;
   assign out_valid = v3;
   assign take = in_valid && in_ready;

`ifdef KMUL_SIGNED_EN
   logic n1, n2;
   assign mx = (in_signed && in_x[WIDTH-1]) ? -in_x : in_x;
   assign my = (in_signed && in_y[WIDTH-1]) ? -in_y : in_y;
   assign res = n2 ? -prod : prod;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         n1 <= 1'b0;
         n2 <= 1'b0;
      end else begin
         if (take) n1 <= in_signed && (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
         if (adv2 && v1) n2 <= n1;
      end
`else
   logic unused_signed;
   assign unused_signed = in_signed;
   assign mx = in_x;
   assign my = in_y;
   assign res = prod;
`endif

   // Middle term z1-z2-z0 is never negative, but is formed at full width so the subtraction cannot wrap early.
   assign mid = PW'(z1) - PW'(z2) - PW'(z0);
   assign prod = (2*WIDTH)'((PW'(z2) << WIDTH) + (mid << HALF) + PW'(z0));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {v1, v2, v3} <= '0;
         {lx, hx, ly, hy, sx, sy, t1} <= '0;
         {z0, z1, z2, t2} <= '0;
         out_prod <= '0;
         out_tag <= '0;
      end else begin
         if (in_ready) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv3) v3 <= v2;
         if (take) begin
            lx <= mx[HALF-1:0];
            hx <= mx[WIDTH-1:HALF];
            ly <= my[HALF-1:0];
            hy <= my[WIDTH-1:HALF];
            sx <= SW'(mx[HALF-1:0]) + SW'(mx[WIDTH-1:HALF]);
            sy <= SW'(my[HALF-1:0]) + SW'(my[WIDTH-1:HALF]);
            t1 <= in_tag;
         end
         if (adv2 && v1) begin
            z0 <= WIDTH'(lx) * WIDTH'(ly);
            z2 <= WIDTH'(hx) * WIDTH'(hy);
            z1 <= Z1W'(sx) * Z1W'(sy);
            t2 <= t1;
         end
         if (adv3 && v2) begin
            out_prod <= res;
            out_tag <= t2;
         end
      end
endmodule
